// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  localparam logic [3:0] COL_IDLE  = 4'hF;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onecold_t;

  // Exactly one low bit is a valid hit; idle and multi-key patterns are not.
  function automatic onecold_t onecold_decode(input logic [3:0] v);
    onecold_t r;
    r.valid = 1'b0;
    r.idx   = 2'd0;
    case (v)
      4'b1110:  r = '{valid: 1'b1, idx: 2'd0};
      4'b1101:  r = '{valid: 1'b1, idx: 2'd1};
      4'b1011:  r = '{valid: 1'b1, idx: 2'd2};
      4'b0111:  r = '{valid: 1'b1, idx: 2'd3};
      COL_IDLE: r = '{valid: 1'b0, idx: 2'd0};
      default:  r = '{valid: 1'b0, idx: 2'd0};
    endcase
    return r;
  endfunction

  // Row drive is always one-cold, so the index needs no validity check.
  function automatic logic [1:0] row_to_idx(input logic [3:0] row);
    return {~row[3] | ~row[2], ~row[3] | ~row[1]};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running dwell counter; strobes once per row dwell at its last count.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic sample
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] r_cnt;

  // Count 0..SCAN_DIV-1 and wrap; nothing but reset restarts the cadence.
  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign sample = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debounce and one pulse per press.
import keypad_pkg::*;

module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column_in,
  output logic [3:0] row_sweep,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Saturating increment so the count never wraps past DEBOUNCE_CNT.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic       w_sample;
  onecold_t   w_col;
  logic [1:0] w_row_idx;
  logic       w_accept;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt,   w_cnt_n;
  logic [3:0]    r_row,   w_row_n;
  logic [1:0]    r_cap_col, w_cap_col_n;
  logic [3:0]    r_code,  w_code_n;
  logic          r_valid, w_valid_n;
  logic          r_held,  w_held_n;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .sample (w_sample)
  );

  assign w_col     = onecold_decode(column_in);
  assign w_row_idx = row_to_idx(r_row);

  // Next-state logic; everything moves only on a sample strobe.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_row_n     = r_row;
    w_cap_col_n = r_cap_col;
    w_code_n    = r_code;
    w_valid_n   = 1'b0;
    w_held_n    = r_held;
    w_accept    = 1'b0;
    if (w_sample) begin
      unique case (r_state)
        SCAN: begin
          if (w_col.valid) begin
            w_cap_col_n = w_col.idx;
            w_cnt_n     = CNT_ONE;
            w_state_n   = DEBOUNCE;
            w_accept    = (CNT_ONE == CNT_MAX);
          end else begin
            w_row_n = {r_row[2:0], r_row[3]};
          end
        end
        DEBOUNCE: begin
          if (w_col.valid && (w_col.idx == r_cap_col)) begin
            w_cnt_n  = sat_inc(r_cnt);
            w_accept = (w_cnt_n == CNT_MAX);
          end else begin
            w_cnt_n   = '0;
            w_row_n   = {r_row[2:0], r_row[3]};
            w_state_n = SCAN;
          end
        end
        PRESSED: begin
          // Any single column, even a different one, keeps the key held.
          if (!w_col.valid) begin
            w_cnt_n = sat_inc(r_cnt);
            if (w_cnt_n == CNT_MAX) begin
              w_cnt_n   = '0;
              w_held_n  = 1'b0;
              w_row_n   = {r_row[2:0], r_row[3]};
              w_state_n = SCAN;
            end
          end else begin
            w_cnt_n = '0;
          end
        end
        default: w_state_n = SCAN;
      endcase
      if (w_accept) begin
        w_code_n  = {w_row_idx, w_cap_col_n};
        w_valid_n = 1'b1;
        w_held_n  = 1'b1;
        w_cnt_n   = '0;
        w_state_n = PRESSED;
      end
    end
  end

  // Control and output registers, reset to the idle scan position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN;
      r_cnt   <= '0;
      r_row   <= ROW_RESET;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_row   <= w_row_n;
      r_code  <= w_code_n;
      r_valid <= w_valid_n;
      r_held  <= w_held_n;
    end
  end

  // Captured column is only consulted after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    r_cap_col <= w_cap_col_n;
  end

  assign row_sweep = r_row;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Scans a 4x4 matrix keypad by driving one row low at a time and reading the four column lines. Each candidate press is debounced over several scan samples. The block emits exactly one single-cycle `key_valid` pulse with a 4-bit key code per physical press. It sits between the keypad pins and the calculator FSM, which consumes `key_code`/`key_valid`.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each row is driven (dwell); must be ≥ 2.
- `DEBOUNCE_CNT`, default 4: consecutive identical samples needed to accept a press or a release; must be ≥ 1.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `column_in`, input, 4: keypad columns, active-low. `4'hF` means no key.
- `row_sweep`, output, 4: row drive, one-cold. Row r is low (`row_sweep[r]=0`).
- `key_code`, output, 4: `{row_idx[1:0], col_idx[1:0]}` of the last accepted key. Held stable until the next accept.
- `key_valid`, output, 1: one-cycle pulse when `key_code` is updated.
- `key_held`, output, 1: high from the accept until the release is confirmed.

## Operation
- Dwell counter runs 0..`SCAN_DIV`-1 and wraps. The sample point is counter == `SCAN_DIV`-1; `column_in` is evaluated only there.
- Column decode:
  - Exactly one bit low → valid, `col_idx` = position of that bit.
  - `4'hF` → idle.
  - Two or more bits low → invalid, treated exactly as idle.
- **SCAN**
  - At each sample, a valid column → capture `row_idx`/`col_idx`, set debounce count = 1, go to DEBOUNCE. The row is not advanced.
  - Otherwise the row rotates: `1110→1101→1011→0111→1110`.
  - If `DEBOUNCE_CNT`==1, go straight to accept.
- **DEBOUNCE** (row frozen)
  - Sample equal to the captured column → count+1.
  - When count reaches `DEBOUNCE_CNT` → accept: update `key_code`, pulse `key_valid`, set `key_held`, go to PRESSED.
  - Sample differs (idle, invalid, or other column) → clear count, advance the row, go to SCAN.
- **PRESSED** (row frozen)
  - Idle/invalid sample → release count+1.
  - Captured-column sample → release count cleared.
  - When release count reaches `DEBOUNCE_CNT` → clear `key_held`, advance the row, go to SCAN.
  - A different single column while held is treated as pressed: no new key, no pulse (no rollover).
- The dwell counter is never reset by state changes; sampling cadence is fixed.
- Only one key is accepted per press-release cycle. Holding a key never repeats.

## Timing
- Reset values:
  - `row_sweep`=`4'b1110`, `key_code`=0, `key_valid`=0, `key_held`=0.
  - State SCAN, all counters 0.
- `rst` wins over all other events in the same cycle. Reset mid-DEBOUNCE or mid-PRESSED gives no pulse and returns to the reset values on the next edge.
- The row changes on the edge following the sample cycle. This gives the columns a full dwell to settle before the next sample.
- Accept latency: `key_valid` is high in the cycle after the `DEBOUNCE_CNT`-th matching sample. That is (`DEBOUNCE_CNT`-1)·`SCAN_DIV`+1 cycles after the first detecting sample edge.
- `key_code` changes on the same edge `key_valid` rises and holds afterward.
- `key_held` rises with `key_valid`. It falls one cycle after the `DEBOUNCE_CNT`-th consecutive idle sample.
- Counter widths:
  - Dwell counter: `$clog2(SCAN_DIV)`.
  - Debounce and release counters: `$clog2(DEBOUNCE_CNT+1)`.
  - Counters saturate; no wrap past `DEBOUNCE_CNT`.

## Structure
- Shared package `keypad_pkg`:
  - State enum {SCAN, DEBOUNCE, PRESSED}.
  - Constants `COL_IDLE`=`4'hF` and `ROW_RESET`=`4'b1110`.
  - Column one-cold-to-index function returning valid/index.
- Sub-module `scan_tick_gen`: the dwell counter, parameterised by `SCAN_DIV`, outputs a one-cycle `sample` strobe. The FSM and row register remain in the top block.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CNT`=3.
- Reset, `column_in`=`4'hF` → `row_sweep` holds `1110` for 4 cycles, then `1101`, `1011`, `0111`, `1110`. All outputs 0.
- Drive `column_in`=`4'b1101` only while `row_sweep`=`1011`, kept pressed → `row_sweep` freezes at `1011`. One `key_valid` pulse 9 cycles after the first detecting sample, with `key_code`=`4'h9` and `key_held`=1. No further pulse over 200 cycles of hold.
- Bounce: column low for 1 sample, then `4'hF` → no `key_valid`. Row advances to `0111` after the failed sample.
- Release after an accepted key → `key_held` falls one cycle after the 3rd consecutive idle sample. Scanning resumes, and a second press of the same key gives a second pulse.
- `column_in`=`4'b1001` on any row → treated as idle: no capture, scanning continues.
- `rst` asserted in DEBOUNCE and again in PRESSED → next edge `row_sweep`=`1110`, `key_held`=0, `key_code`=0. No pulse is emitted.
